rr_request_arbiter: RTL and testbench
=====================================

RR_REQUEST_ARBITER -- requirements
Module: rr_request_arbiter

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 15, giving the maximum cycles an offered request waits for ack (legal range 1..255).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have the port req_in, input, 3 bits: raw level/pulse requests from sources 0..2; any combination is legal.
REQ-005 The block SHALL have the port ack, input, 1 bit: the downstream grant encoder has consumed the current request.
REQ-006 The block SHALL have the port request, output, 3 bits: registered request to the downstream grant encoder, always 3'b000 or one-hot.
REQ-007 The block SHALL have the port valid, output, 1 bit: high exactly when request is non-zero.
REQ-008 The block SHALL have the port timeout_err, output, 1 bit: one-cycle pulse when an offer is dropped for lack of ack.
REQ-009 The block SHALL have the port timeout_cnt, output, 8 bits: saturating count of dropped offers.

Function
REQ-010 The block SHALL keep a 3-bit sticky register, pending, in which each bit is set on any edge where the matching req_in bit is high.
REQ-011 The block SHALL implement the two-state FSM IDLE/OFFER, with request=3'b000 and valid=0 in IDLE.
REQ-012 In IDLE, the eligible set SHALL be pending | req_in; if it is non-zero at an edge, the block SHALL register the one-hot selection into request, set valid=1, clear the timer and enter OFFER at that edge (latency: request visible one cycle after req_in).
REQ-013 Selection SHALL be round-robin: the block searches eligible bits starting at (ptr+1) mod 3 and ascending with wrap, where ptr is the index of the last completed or dropped offer.
REQ-014 In OFFER, request SHALL be held stable and one-hot until the state exits; new req_in activity only updates pending.
REQ-015 In OFFER, when ack is sampled high, the block SHALL clear the selected pending bit, set ptr to the selected index, drive request=3'b000 and valid=0, and enter IDLE.
REQ-016 If the same req_in bit is high on the ack edge, that pending bit SHALL remain set, because re-arm wins over clear.
REQ-017 In OFFER without ack, the timer SHALL increment each cycle.
REQ-018 When the timer reaches TIMEOUT-1 with no ack, the block SHALL, at the next edge: clear the selected pending bit, set ptr to the selected index, pulse timeout_err for one cycle, increment timeout_cnt (saturating at 255), and enter IDLE.
REQ-019 If ack and timeout coincide on the same edge, the block SHALL treat the offer as acked: no timeout_err, timeout_cnt unchanged.
REQ-020 The block SHALL leave at least one cycle of request=3'b000 between any two consecutive offers, even to the same source.
REQ-021 The block SHALL ignore ack in IDLE, with no state change.
REQ-022 With all three sources continuously requesting, the block SHALL grant them in the order 0,1,2,0,... with no source starved.

Reset
REQ-023 While rst_n is low at an edge, the block SHALL set: state=IDLE, pending=3'b000, ptr=2 (so the first search starts at bit 0), timer=0, request=3'b000, valid=0, timeout_err=0, timeout_cnt=0.
REQ-024 Reset asserted mid-OFFER SHALL discard the offer with no timeout_err pulse, and request SHALL be 3'b000 after that edge.
REQ-025 req_in SHALL be ignored on reset edges: pending is not set.

Verification
REQ-026 Single source: reset released, req_in=3'b010 for 1 cycle -> request=3'b010, valid=1 on the next cycle; ack one cycle later -> request=3'b000 on the following cycle, pending=0.
REQ-027 Contention: req_in=3'b111 held, ack returned one cycle after each offer -> request sequence 001,000,010,000,100,000,001; never multi-hot.
REQ-028 Timeout: TIMEOUT=15, req_in=3'b001 pulse, ack held low -> request=001 for exactly 15 cycles, then timeout_err=1 for 1 cycle, timeout_cnt=1, request=000.
REQ-029 Coincidence: ack asserted on the same edge as the timeout edge -> no timeout_err, timeout_cnt unchanged; req_in[sel] high on the ack edge -> same source re-offered after one idle cycle.
REQ-030 Reset mid-offer: rst_n driven low during OFFER for 1 edge -> request=000, valid=0, pending=0, timeout_cnt=0; the next req_in=3'b100 is offered normally.
REQ-031 Saturation: force 256 timeouts -> timeout_cnt stays 255 and timeout_err still pulses once per drop.

Source files
------------

// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter over three sticky request sources. It offers one source at a
// time to a downstream grant encoder and drops the offer if no ack arrives in time.
module rr_request_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_in,
  input  logic       ack,
  output logic [2:0] request,
  output logic       valid,
  output logic       timeout_err,
  output logic [7:0] timeout_cnt
);

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_reg, state_next;
  logic [2:0] pending_reg, pending_next;
  logic [2:0] request_reg, request_next;
  logic       valid_reg, valid_next;
  logic       terr_reg, terr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] timer_reg, timer_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] sel_reg, sel_next;

  logic [2:0] eligible;
  logic [1:0] start_idx;
  logic [1:0] cand_idx [3];
  logic [2:0] cand_hit;
  logic [1:0] pick_idx;
  logic [2:0] pick_onehot;

  assign eligible  = pending_reg | req_in;
  assign start_idx = (ptr_reg == 2'd2) ? 2'd0 : ptr_reg + 2'd1;

  // Candidate gi is the source visited gi steps after the one following ptr.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum          = {1'b0, start_idx} + 3'(gi);
    assign cand_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign cand_hit[gi] = eligible[cand_idx[gi]];
  end

  always_comb begin
    pick_idx = cand_idx[2];
    if (cand_hit[0])      pick_idx = cand_idx[0];
    else if (cand_hit[1]) pick_idx = cand_idx[1];
    pick_onehot = 3'b001 << pick_idx;
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg | req_in;
    request_next = request_reg;
    valid_next   = valid_reg;
    terr_next    = 1'b0;
    cnt_next     = cnt_reg;
    timer_next   = timer_reg;
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    case (state_reg)
      IDLE: begin
        if (eligible != 3'b000) begin
          request_next = pick_onehot;
          valid_next   = 1'b1;
          sel_next     = pick_idx;
          timer_next   = 8'd0;
          state_next   = OFFER;
        end
      end
      OFFER: begin
        if (ack || timer_reg == TLAST) begin
          // A source re-requesting on the closing edge stays pending.
          pending_next = (pending_reg & ~request_reg) | req_in;
          ptr_next     = sel_reg;
          request_next = 3'b000;
          valid_next   = 1'b0;
          state_next   = IDLE;
          if (!ack) begin
            terr_next = 1'b1;
            if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
          end
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= 3'b000;
      request_reg <= 3'b000;
      valid_reg   <= 1'b0;
      terr_reg    <= 1'b0;
      cnt_reg     <= 8'd0;
      timer_reg   <= 8'd0;
      ptr_reg     <= 2'd2;
      sel_reg     <= 2'd0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      request_reg <= request_next;
      valid_reg   <= valid_next;
      terr_reg    <= terr_next;
      cnt_reg     <= cnt_next;
      timer_reg   <= timer_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
    end
  end

  assign request     = request_reg;
  assign valid       = valid_reg;
  assign timeout_err = terr_reg;
  assign timeout_cnt = cnt_reg;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Scoreboard bench for rr_request_arbiter: a cycle model predicts every output
// vector, plus directed checks of the reset, contention, timeout and saturation cases.
module tb_rr_request_arbiter;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_in = 3'b000;
  logic       ack = 1'b0;
  logic [2:0] request;
  logic       valid;
  logic       timeout_err;
  logic [7:0] timeout_cnt;

  rr_request_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .ack(ack),
    .request(request), .valid(valid), .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] sb_q[$];

  // reference model state
  bit         m_off;
  logic [2:0] m_pend, m_req;
  int         m_ptr, m_sel, m_timer, m_cnt;
  bit         m_terr;
  bit         m_quiet;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r_n, input logic [2:0] r, input logic a);
    m_terr = 1'b0;
    if (!r_n) begin
      m_off = 0; m_pend = 3'b000; m_req = 3'b000; m_ptr = 2; m_sel = 0; m_timer = 0; m_cnt = 0;
    end else if (!m_off) begin
      logic [2:0] elig;
      elig = m_pend | r;
      if (elig != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          int idx;
          idx = (m_ptr + k) % 3;
          if (elig[idx] && !m_off) begin
            m_off = 1; m_sel = idx; m_req = 3'b000; m_req[idx] = 1'b1; m_timer = 0;
          end
        end
      end
      m_pend = m_pend | r;
    end else if (a || m_timer == T - 1) begin
      m_pend[m_sel] = 1'b0;
      m_pend = m_pend | r;
      m_ptr = m_sel; m_req = 3'b000; m_off = 0;
      if (!a) begin
        m_terr = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      if (!m_quiet) $display("txn src=%0d %s t=%0t", m_sel, a ? "acked" : "dropped", $time);
    end else begin
      m_timer++;
      m_pend = m_pend | r;
    end
  endtask

  task automatic step(input logic r_n, input logic [2:0] r, input logic a);
    logic [12:0] exp;
    @(negedge clk);
    rst_n = r_n; req_in = r; ack = a;
    model_step(r_n, r, a);
    sb_q.push_back({m_req, (m_req != 3'b000), m_terr, 8'(m_cnt)});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check("cyc", {request, valid, timeout_err, timeout_cnt}, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp27 [7];
    int ones, pulses, guard;
    exp27 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    m_quiet = 0;

    // reset, including req_in asserted on a reset edge
    step(0, 3'b000, 0);
    step(0, 3'b111, 0);
    check("rst_req", request, 3'b000);
    check("rst_valid", valid, 1'b0);
    check("rst_cnt", timeout_cnt, 8'd0);
    step(1, 3'b000, 0);
    check("rst_nopend", request, 3'b000);

    // single source
    step(1, 3'b010, 0);
    check("s1_req", request, 3'b010);
    check("s1_valid", valid, 1'b1);
    step(1, 3'b000, 1);
    check("s1_ack", request, 3'b000);
    repeat (3) step(1, 3'b000, 0);
    check("s1_pend0", request, 3'b000);
    step(1, 3'b000, 1);
    check("idle_ack", valid, 1'b0);

    // contention from a fresh pointer
    step(0, 3'b000, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 3'b111, m_req != 3'b000);
      check($sformatf("rr%0d", i), request, exp27[i]);
      check("onehot", $onehot0(request), 1'b1);
    end
    step(1, 3'b000, 1);

    // timeout
    step(0, 3'b000, 0);
    step(1, 3'b001, 0);
    ones = (request == 3'b001) ? 1 : 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 3'b000, 0);
      if (request == 3'b001) ones++;
      if (timeout_err) begin
        pulses++;
        check("to_req0", request, 3'b000);
      end
    end
    check("to_len", ones, T);
    check("to_pulses", pulses, 1);
    check("to_cnt", timeout_cnt, 8'd1);

    // ack coincident with the timeout edge, source re-arming on that edge
    step(1, 3'b001, 0);
    repeat (T - 1) step(1, 3'b000, 0);
    step(1, 3'b001, 1);
    check("co_err", timeout_err, 1'b0);
    check("co_cnt", timeout_cnt, 8'd1);
    check("co_gap", request, 3'b000);
    step(1, 3'b000, 0);
    check("co_reoffer", request, 3'b001);
    step(1, 3'b000, 1);

    // reset mid-offer
    step(1, 3'b010, 0);
    step(1, 3'b000, 0);
    step(0, 3'b000, 0);
    check("mr_req", request, 3'b000);
    check("mr_valid", valid, 1'b0);
    check("mr_err", timeout_err, 1'b0);
    check("mr_cnt", timeout_cnt, 8'd0);
    step(1, 3'b100, 0);
    check("mr_next", request, 3'b100);
    step(1, 3'b000, 1);
    repeat (2) step(1, 3'b000, 0);
    check("mr_pend0", request, 3'b000);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(($urandom_range(0, 99) != 0), r, ($urandom_range(0, 2) == 0));
      check("rnd_onehot", $onehot0(request), 1'b1);
    end

    // counter saturation
    m_quiet = 1;
    step(0, 3'b000, 0);
    pulses = 0;
    guard = 0;
    while (pulses < 260 && guard < 6000) begin
      step(1, m_off ? 3'b000 : 3'b001, 0);
      if (timeout_err) pulses++;
      guard++;
    end
    check("sat_pulses", pulses, 260);
    check("sat_cnt", timeout_cnt, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
